// File: rtl/reg_file_8x16_pkg.sv
// Shared constants for the 8x16 register file: widths, FSM encoding and
// the address-to-one-hot decode helper.
package reg_file_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  // FSM encoding kept as plain constants for compatibility with older tools
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_CLEAR = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Turn a register address into a one-hot select vector
  function automatic logic [NREG-1:0] onehot_sel(input logic [AW-1:0] adr);
    onehot_sel      = '0;
    onehot_sel[adr] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_8x16_if.sv
// Register-file bus: write strobe/address/data, clear request, two read
// ports and the status outputs. master = datapath side, slave = reg file.
interface reg_file_8x16_if;
  import reg_file_pkg::*;

  logic          we;
  logic [AW-1:0] W_Adr;
  logic [DW-1:0] W;
  logic [AW-1:0] R_Adr;
  logic [AW-1:0] S_Adr;
  logic          clr;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic          busy;
  logic          wr_ack;

  modport master (
    output we, W_Adr, W, R_Adr, S_Adr, clr,
    input  R, S, busy, wr_ack
  );

  modport slave (
    input  we, W_Adr, W, R_Adr, S_Adr, clr,
    output R, S, busy, wr_ack
  );

endinterface

// File: rtl/reg_file_8x16_reg16.sv
// One DW-bit storage register: synchronous active-low reset, synchronous
// clear (used by the clear-all sequence) and load enable. Clear beats load.
module reg16
  import reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_reg;

  // Reset, then clear, then load
  always_ff @(posedge clk) begin
    if (!reset_n)  q_reg <= '0;
    else if (clr)  q_reg <= '0;
    else if (ld)   q_reg <= d;
  end

  assign q = q_reg;

endmodule

// File: rtl/reg_file_8x16.sv
// 8-entry x 16-bit register file with one-shot qualified write strobe,
// two combinational read ports and a sequenced clear-all (one register per
// cycle). Optional macro REG_FILE_WR_BYPASS_EN forwards the write data to a
// read port addressing the register being written in the same cycle.
module reg_file_8x16
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  reg_file_8x16_if.slave    bus
);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          we_q_reg;
  logic          wr_ack_reg;
  logic          wr_pulse;
  logic          wr_commit;
  logic [NREG-1:0] wr_sel;
  logic [NREG-1:0] clr_sel;
  logic [DW-1:0] q_arr [NREG];
  logic [DW-1:0] r_data;
  logic [DW-1:0] s_data;

  // A write commits only on a rising strobe while idle and not pre-empted by clr
  assign wr_pulse  = bus.we & ~we_q_reg;
  assign wr_commit = reset_n & (state_reg == ST_IDLE) & wr_pulse & ~bus.clr;

  assign wr_sel  = onehot_sel(bus.W_Adr) & {NREG{wr_commit}};
  assign clr_sel = onehot_sel(cnt_reg) & {NREG{state_reg == ST_CLEAR}};

  // Clear sequencer next-state: walk cnt 0..7 once, then a single DONE cycle
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.clr) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_reg == AW'(NREG - 1)) state_next = ST_DONE;
        else                          cnt_next   = cnt_reg + 1'b1;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Control state; we_q resets high so a strobe held through reset is ignored
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      we_q_reg   <= 1'b1;
      wr_ack_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      we_q_reg   <= bus.we;
      wr_ack_reg <= wr_commit;
    end
  end

  // Storage: one loadable register per address
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
      reg16 u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .ld      (wr_sel[gi]),
        .clr     (clr_sel[gi]),
        .d       (bus.W),
        .q       (q_arr[gi])
      );
    end
  endgenerate

  // Read ports straight from register state, with optional same-cycle forwarding
  always_comb begin
    r_data = q_arr[bus.R_Adr];
    s_data = q_arr[bus.S_Adr];
`ifdef REG_FILE_WR_BYPASS_EN
    if (wr_commit && (bus.R_Adr == bus.W_Adr)) r_data = bus.W;
    if (wr_commit && (bus.S_Adr == bus.W_Adr)) s_data = bus.W;
`else
`endif
  end

  assign bus.R      = r_data;
  assign bus.S      = s_data;
  assign bus.busy   = (state_reg == ST_CLEAR);
  assign bus.wr_ack = wr_ack_reg;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Self-checking bench for reg_file_8x16: a fixed vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_reg_file_8x16;

`ifdef REG_FILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  reg_file_8x16_if bus_if ();

  reg_file_8x16 dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  logic [15:0] mem [8];
  logic        m_weq;
  logic        m_ack;
  int          m_phase;   // 0 idle, 1 clearing, 2 done
  int          m_left;    // registers still to clear

  task automatic model_edge();
    logic pulse;
    logic nack;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0;
      m_weq = 1'b1; m_ack = 1'b0; m_phase = 0; m_left = 0;
      return;
    end
    pulse = bus_if.we & ~m_weq;
    nack  = 1'b0;
    if (m_phase == 0) begin
      if (bus_if.clr) begin
        m_phase = 1; m_left = 8;
      end else if (pulse) begin
        mem[bus_if.W_Adr] = bus_if.W;
        nack = 1'b1;
      end
    end else if (m_phase == 1) begin
      mem[8 - m_left] = 16'h0;
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_weq = bus_if.we;
    m_ack = nack;
  endtask

  function automatic logic [15:0] exp_read(input logic [2:0] adr);
    logic fwd;
    fwd = BYPASS && rst_n && (m_phase == 0) && !bus_if.clr && bus_if.we && !m_weq
          && (adr == bus_if.W_Adr);
    return fwd ? bus_if.W : mem[adr];
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string tag);
    cmp({tag, "_R"},      bus_if.R, exp_read(bus_if.R_Adr));
    cmp({tag, "_S"},      bus_if.S, exp_read(bus_if.S_Adr));
    cmp({tag, "_busy"},   16'(bus_if.busy), 16'(m_phase == 1));
    cmp({tag, "_wr_ack"}, 16'(bus_if.wr_ack), 16'(m_ack));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] w,
                       input logic [2:0] ra, input logic [2:0] sa, input logic c);
    bus_if.we = we; bus_if.W_Adr = wa; bus_if.W = w;
    bus_if.R_Adr = ra; bus_if.S_Adr = sa; bus_if.clr = c;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] w;
    logic [2:0]  ra;
    logic [2:0]  sa;
    logic        c;
    logic [15:0] er;
    logic [15:0] es;
    logic        ebusy;
    logic        eack;
  } vec_t;

  vec_t vecs [13];
  int   busy_cnt;
  logic [15:0] old6;

  initial begin
    // held-through-reset strobe must not write; then one clean rising edge writes
    for (int i = 0; i < 5; i++) vecs[i] = '{1, 3, 16'hBEEF, 3, 3, 0, 16'h0, 16'h0, 0, 0};
    vecs[5]  = '{0, 3, 16'hBEEF, 3, 3, 0, 16'h0,    16'h0,    0, 0};
    vecs[6]  = '{1, 3, 16'hBEEF, 3, 3, 0, 16'hBEEF, 16'hBEEF, 0, 1};
    vecs[7]  = '{1, 3, 16'hBEEF, 3, 3, 0, 16'hBEEF, 16'hBEEF, 0, 0};
    // long-held strobe writes once; changed data without re-strobe is ignored
    vecs[8]  = '{0, 5, 16'h1234, 5, 5, 0, 16'h0,    16'h0,    0, 0};
    vecs[9]  = '{1, 5, 16'h1234, 5, 5, 0, 16'h1234, 16'h1234, 0, 1};
    vecs[10] = '{1, 5, 16'h1234, 5, 5, 0, 16'h1234, 16'h1234, 0, 0};
    vecs[11] = '{1, 5, 16'h5555, 5, 5, 0, 16'h1234, 16'h1234, 0, 0};
    vecs[12] = '{1, 5, 16'h5555, 3, 5, 0, 16'hBEEF, 16'h1234, 0, 0};

    drive(1, 3, 16'hBEEF, 3, 3, 0);
    rst_n = 1'b0;
    cycle(); cycle();
    check("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].w, vecs[i].ra, vecs[i].sa, vecs[i].c);
      cycle();
      cmp($sformatf("vec%0d_R", i), bus_if.R, vecs[i].er);
      cmp($sformatf("vec%0d_S", i), bus_if.S, vecs[i].es);
      cmp($sformatf("vec%0d_busy", i), 16'(bus_if.busy), 16'(vecs[i].ebusy));
      cmp($sformatf("vec%0d_ack", i), 16'(bus_if.wr_ack), 16'(vecs[i].eack));
      $display("vec %0d: we=%b W_Adr=%0d W=%h R=%h S=%h ack=%b", i, vecs[i].we,
               vecs[i].wa, vecs[i].w, bus_if.R, bus_if.S, bus_if.wr_ack);
    end

    // fill all registers, then clear-all: busy exactly 8 cycles
    for (int i = 0; i < 8; i++) begin
      drive(0, 3'(i), 16'h0101 * 16'(i), 3'(i), 3'(i), 0); cycle();
      bus_if.we = 1'b1; cycle(); check("fill");
      cmp($sformatf("fill%0d", i), bus_if.R, 16'h0101 * 16'(i));
      $display("fill reg %0d = %h", i, bus_if.R);
    end
    drive(0, 0, 16'h0, 0, 7, 1);
    cycle(); check("clr_start");
    busy_cnt = bus_if.busy ? 1 : 0;
    bus_if.clr = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cycle(); check("clr_run");
      if (bus_if.busy) busy_cnt++;
    end
    cmp("clr_busy_len", 16'(busy_cnt), 16'd8);
    $display("clear-all: busy cycles=%0d", busy_cnt);
    for (int i = 0; i < 8; i++) begin
      bus_if.R_Adr = 3'(i); #1;
      cmp($sformatf("cleared%0d", i), bus_if.R, 16'h0);
    end

    // clr and rising strobe together: clear wins, no write, no ack
    drive(0, 2, 16'hFFFF, 2, 2, 0); cycle();
    drive(1, 2, 16'hFFFF, 2, 2, 1); #1; check("clrwr_pre");
    cycle(); check("clrwr");
    bus_if.clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(); check("clrwr_run");
      cmp("clrwr_noack", 16'(bus_if.wr_ack), 16'h0);
    end
    cmp("clrwr_reg2", bus_if.R, 16'h0);
    $display("clr+write: reg2=%h", bus_if.R);

    // reset during clear aborts the sequence
    drive(0, 4, 16'h7777, 4, 1, 0); cycle();
    bus_if.we = 1'b1; cycle();
    drive(0, 1, 16'h1111, 4, 1, 1); cycle();
    bus_if.clr = 1'b0; cycle(); cycle(); cycle();
    rst_n = 1'b0; cycle(); check("midclr_rst");
    cmp("midclr_busy", 16'(bus_if.busy), 16'h0);
    rst_n = 1'b1;
    bus_if.we = 1'b0; cycle();
    bus_if.we = 1'b1; cycle(); check("post_rst_wr");
    cmp("post_rst_reg1", bus_if.S, 16'h1111);
    cmp("post_rst_reg4", bus_if.R, 16'h0);
    $display("reset mid-clear: reg1=%h reg4=%h", bus_if.S, bus_if.R);

    // same-cycle forwarding (old value when forwarding is not built in)
    drive(0, 6, 16'h3C3C, 6, 0, 0); cycle();
    bus_if.we = 1'b1; cycle();
    bus_if.we = 1'b0; cycle();
    old6 = 16'h3C3C;
    drive(1, 6, 16'hA5A5, 6, 6, 0); #1;
    check("bypass_pre");
    cmp("bypass_R", bus_if.R, BYPASS ? 16'hA5A5 : old6);
    $display("bypass: R in pulse cycle=%h", bus_if.R);
    cycle(); check("bypass_post");
    cmp("bypass_after", bus_if.R, 16'hA5A5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 3'($urandom),
            3'($urandom), ($urandom_range(0, 19) == 0));
      rst_n = ($urandom_range(0, 79) != 0);
      #1; check("rnd_pre");
      cycle(); check("rnd");
      $display("rnd %0d: rst_n=%b we=%b clr=%b W_Adr=%0d R=%h S=%h busy=%b ack=%b", i,
               rst_n, bus_if.we, bus_if.clr, bus_if.W_Adr, bus_if.R, bus_if.S,
               bus_if.busy, bus_if.wr_ack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
